text_ram_arbiter: RTL

Shares the single-port synchronous text RAM between two masters: the VT100 parser's text controller (character reads/writes for printing, erase and scroll) and the display renderer's character prefetch reads. The renderer normally wins; a starvation counter guarantees the parser a slot. The block sits between the parser's RAM request/result path, the renderer fetch port and the RAM macro. It issues at most one RAM access per cycle and returns read data tagged to the correct master.

---
 rtl/text_ram_arbiter_pkg.sv | 25 ++
 rtl/text_ram_arbiter_tag.sv | 60 ++++++
 rtl/text_ram_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/text_ram_arbiter_pkg.sv
// text_ram_arbiter_pkg
//   Shared types for the text RAM arbiter: who owns a RAM access and the
//   parser slot state. Imported by text_ram_arbiter and ram_tag_pipe.
package text_ram_arbiter_pkg;

    // Owner of a RAM access as it moves down the return pipe.
    typedef enum logic [1:0] {
        OWNER_NONE   = 2'd0,
        OWNER_PARSER = 2'd1,
        OWNER_RENDER = 2'd2
    } ArbOwner_t;

    // Parser slot: one outstanding access at a time, three cycles per access.
    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_ISSUED = 2'd1,
        P_DONE   = 2'd2
    } ParserSlot_t;

    // Saturating increment bounded by a limit.
    function automatic logic [3:0] satInc(input logic [3:0] val, input logic [3:0] lim);
        return (val < lim) ? val + 4'd1 : val;
    endfunction

endpackage

// File: rtl/text_ram_arbiter_tag.sv
// ram_tag_pipe
//   Two-stage owner tag shift register that follows every RAM access and
//   steers the RAM read data back to the master that issued it.
//   clk, rst      : clock, asynchronous active-high reset
//   grantOwner    : owner granted this cycle (OWNER_NONE when idle)
//   ramRdata      : RAM output, valid one cycle after the access is on ram_*
//   issueOwner    : owner of the access currently driven onto ram_*
//   pDone, pRdata : parser completion pulse and held read data
//   rValid, rRdata: renderer data valid pulse and held read data
module ram_tag_pipe
    import text_ram_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ArbOwner_t         grantOwner,
    input  logic [DATA_W-1:0] ramRdata,
    output ArbOwner_t         issueOwner,
    output logic              pDone,
    output logic [DATA_W-1:0] pRdata,
    output logic              rValid,
    output logic [DATA_W-1:0] rRdata
);

    ArbOwner_t         tagS1, tagS2;
    logic [DATA_W-1:0] pHold, rHold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagS1 <= OWNER_NONE;
            tagS2 <= OWNER_NONE;
        end else begin
            tagS1 <= grantOwner;
            tagS2 <= tagS1;
        end
    end

    // Hold registers keep the last returned word between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pHold <= '0;
            rHold <= '0;
        end else begin
            if (tagS2 == OWNER_PARSER) pHold <= ramRdata;
            if (tagS2 == OWNER_RENDER) rHold <= ramRdata;
        end
    end

    // Return data passes straight through in the completion cycle so the
    // data and its valid pulse line up; otherwise the held word is shown.
    always_comb begin
        issueOwner = tagS1;
        pDone      = (tagS2 == OWNER_PARSER);
        rValid     = (tagS2 == OWNER_RENDER);
        pRdata     = pDone  ? ramRdata : pHold;
        rRdata     = rValid ? ramRdata : rHold;
    end

endmodule

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter
//   Shares the single-port text RAM between the VT100 parser (read/write,
//   one access per 3-cycle slot) and the renderer prefetch (reads, one per
//   cycle). Renderer has priority; a starvation counter forces the parser
//   through after STARVE_LIMIT consecutive lost cycles.
//   Parser   : p_req/p_we/p_addr/p_wdata in, p_done/p_rdata out
//   Renderer : r_req/r_addr in, r_ack (combinational), r_valid/r_rdata out
//   RAM      : ram_en/ram_we/ram_addr/ram_wdata registered out, ram_rdata in
//   debug    : {owner of access on ram_*, parser slot state}
module text_ram_arbiter
    import text_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_done,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_ack,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        debug
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } TextRamPort_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    ParserSlot_t  pState, pStateNext;
    logic [3:0]   starveCnt, starveCntNext;
    logic         pElig, pWants, pGrant, rGrant;
    ArbOwner_t    grantOwner, issueOwner;
    TextRamPort_t ramCmd, ramCmdNext;
    logic         ramEn;

    // Parser slot FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pState <= P_IDLE;
        else     pState <= pStateNext;
    end

    // Parser slot FSM: next state
    always_comb begin
        pStateNext = pState;
        unique case (pState)
            P_IDLE:   if (pGrant) pStateNext = P_ISSUED;
            P_ISSUED: pStateNext = P_DONE;
            P_DONE:   pStateNext = P_IDLE;
            default:  pStateNext = P_IDLE;
        endcase
    end

    // Parser slot FSM: outputs. Only an idle slot may be granted, so a
    // p_req still high during the p_done cycle is not taken again.
    always_comb begin
        pElig  = (pState == P_IDLE);
        pWants = p_req && pElig;
    end

    // Arbitration: renderer wins ties unless the parser has starved.
    always_comb begin
        pGrant = 1'b0;
        rGrant = 1'b0;
        if (pWants && r_req) begin
            if (starveCnt == STARVE_MAX) pGrant = 1'b1;
            else                         rGrant = 1'b1;
        end else begin
            pGrant = pWants;
            rGrant = r_req;
        end
        if (pGrant)      grantOwner = OWNER_PARSER;
        else if (rGrant) grantOwner = OWNER_RENDER;
        else             grantOwner = OWNER_NONE;
    end

    always_comb begin
        if (!pWants || pGrant) starveCntNext = '0;
        else                   starveCntNext = satInc(starveCnt, STARVE_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starveCnt <= '0;
        else     starveCnt <= starveCntNext;
    end

    // Winner's command registered onto the RAM port. we is cleared in idle
    // cycles; addr/wdata hold so the bus does not toggle needlessly.
    always_comb begin
        ramCmdNext    = ramCmd;
        ramCmdNext.we = 1'b0;
        if (pGrant) begin
            ramCmdNext.we    = p_we;
            ramCmdNext.addr  = p_addr;
            ramCmdNext.wdata = p_wdata;
        end else if (rGrant) begin
            ramCmdNext.addr  = r_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramCmd <= '0;
            ramEn  <= 1'b0;
        end else begin
            ramCmd <= ramCmdNext;
            ramEn  <= pGrant || rGrant;
        end
    end

    ram_tag_pipe #(
        .DATA_W(DATA_W)
    ) uTagPipe (
        .clk       (clk),
        .rst       (rst),
        .grantOwner(grantOwner),
        .ramRdata  (ram_rdata),
        .issueOwner(issueOwner),
        .pDone     (p_done),
        .pRdata    (p_rdata),
        .rValid    (r_valid),
        .rRdata    (r_rdata)
    );

    always_comb begin
        r_ack     = rGrant && !rst;
        ram_en    = ramEn;
        ram_we    = ramCmd.we;
        ram_addr  = ramCmd.addr;
        ram_wdata = ramCmd.wdata;
        debug     = {issueOwner, pState};
    end

endmodule
